adder_req_arbiter: RTL

//  Shares one ripple_cla16 adder between NREQ requesters, e.g. ALU and PC incrementer.

---
 rtl/adder_req_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/adder_req_arbiter.sv
// adder_req_arbiter: round-robin sharing of one ripple_cla16 adder among NREQ requesters.
// Optional watchdog abort when ARB_TIMEOUT_EN is defined. Rev 1.0
`default_nettype none

module adder_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      res,
  output logic                  res_cout,
  output logic                  err,
  output logic                  add_en,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic                  add_ready,
  input  logic [WIDTH-1:0]      add_out,
  input  logic                  add_cout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("adder_req_arbiter: NREQ must be 2..4");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("adder_req_arbiter: TIMEOUT must be >= 1");
  end

  logic [1:0]       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [PW-1:0]    r_gidx;
  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_cin;
  logic [WIDTH-1:0] r_res;
  logic             r_res_cout;

  logic             w_found;
  logic [NREQ-1:0]  w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;
  int               w_j;

  // Search begins one past the last served requester and wraps.
  always_comb begin
    w_found   = 1'b0;
    w_win_oh  = '0;
    w_win_idx = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    w_j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[w_j]) begin
        w_found        = 1'b1;
        w_win_oh[w_j]  = 1'b1;
        w_win_idx      = PW'(w_j);
        w_sel_a        = req_a[w_j*WIDTH +: WIDTH];
        w_sel_b        = req_b[w_j*WIDTH +: WIDTH];
        w_sel_cin      = req_cin[w_j];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_abort;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_ptr      <= PW'(NREQ - 1);
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_add_cin  <= 1'b0;
      r_res      <= '0;
      r_res_cout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_abort    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt     <= w_win_oh;
            r_gidx    <= w_win_idx;
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_add_cin <= w_sel_cin;
            r_state   <= S_ISSUE;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_abort   <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          if (add_ready) begin
            r_res      <= add_out;
            r_res_cout <= add_cout;
            r_state    <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_abort <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_gnt   <= '0;
          r_ptr   <= r_gidx;
          r_state <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
          r_abort <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = (r_state == S_DONE) ? r_gnt : '0;
  assign add_en   = (r_state == S_ISSUE);
  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign add_cin  = r_add_cin;
  assign res      = r_res;
  assign res_cout = r_res_cout;
`ifdef ARB_TIMEOUT_EN
  assign err      = (r_state == S_DONE) && r_abort;
`else
  assign err      = 1'b0;
`endif

endmodule

`default_nettype wire
